// File: rtl/ddr2_rd_arbiter.sv
// ddr2_rd_arbiter: round-robin arbiter that shares the single ddr2_mgr read
// port between up to four read clients. Only one transfer is outstanding at a
// time. The winner's address and length are latched, the request is forwarded,
// and the burst is tracked until rd_data_valid drops. At the end the arbiter
// checks the beat count against the requested length.
//
// Optional feature, macro DDR2_RD_ARB_TIMEOUT_EN: a watchdog aborts ST_REQ or
// ST_WAIT_DATA after TIMEOUT_CYC cycles, pulses cl_done and sets the sticky
// timeout_err output. With the macro undefined the arbiter waits indefinitely
// and has no timeout_err port.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no transfer; round-robin arbitration among cl_req
// ST_REQ       | rd_mem_req held high, waiting for rd_mem_grant
// ST_WAIT_DATA | request accepted, waiting for the first valid beat
// ST_XFER      | counting valid beats until rd_data_valid drops
// ST_DONE      | cl_done pulse to the owner, beat count vs. length check

module ddr2_rd_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 25,
   parameter int LEN_W       = 10,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        cl_req,
   input  logic [NUM_REQ*ADDR_W-1:0] cl_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  cl_len,
   output logic [NUM_REQ-1:0]        cl_gnt,
   output logic [NUM_REQ-1:0]        cl_done,
   output logic [1:0]                cl_owner,
   output logic                      rd_mem_req,
   output logic [ADDR_W-1:0]         rd_mem_addr,
   output logic [LEN_W-1:0]          rd_xfr_len,
   input  logic                      rd_mem_grant,
   input  logic                      rd_data_valid,
   output logic                      busy,
   output logic                      len_err
`ifdef DDR2_RD_ARB_TIMEOUT_EN
   ,
   output logic                      timeout_err
`endif
);

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("ddr2_rd_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_DATA,
      ST_XFER,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic                 rd_mem_req_q, rd_mem_req_d;
   logic [NUM_REQ-1:0]   cl_gnt_q, cl_gnt_d;
   logic [NUM_REQ-1:0]   cl_done_q, cl_done_d;
   logic [1:0]           cl_owner_q, cl_owner_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic                 len_err_q, len_err_d;

   logic [3:0]           req_pad;
   logic [1:0]           cand;
   logic [1:0]           win;
   logic                 found;
   logic [NUM_REQ-1:0]   own_oh;

`ifdef DDR2_RD_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                 timeout_err_q, timeout_err_d;
`endif

   // Round-robin search starting one past the last granted client.
   always_comb begin
      req_pad = 4'(cl_req);
      found   = 1'b0;
      win     = 2'd0;
      cand    = 2'd0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && req_pad[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // One-hot decode of the current owner for the gnt/done pulses.
   always_comb begin
      own_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         own_oh[i] = (cl_owner_q == 2'(i));
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      rd_mem_req_d = rd_mem_req_q;
      cl_gnt_d     = '0;
      cl_done_d    = '0;
      cl_owner_d   = cl_owner_q;
      rr_ptr_d     = rr_ptr_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      len_err_d    = len_err_q;
`ifdef DDR2_RD_ARB_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               cl_owner_d   = win;
               addr_d       = cl_addr[int'(win)*ADDR_W +: ADDR_W];
               len_d        = cl_len[int'(win)*LEN_W +: LEN_W];
               rd_mem_req_d = 1'b1;
               state_d      = ST_REQ;
`ifdef DDR2_RD_ARB_TIMEOUT_EN
               wait_cnt_d   = '0;
`endif
            end
         end
         ST_REQ: begin
            if (rd_mem_grant) begin
               rd_mem_req_d = 1'b0;
               cl_gnt_d     = own_oh;
               rr_ptr_d     = cl_owner_q;
               state_d      = ST_WAIT_DATA;
`ifdef DDR2_RD_ARB_TIMEOUT_EN
               wait_cnt_d   = '0;
            end else if (wait_cnt_q == TO_LAST) begin
               rd_mem_req_d  = 1'b0;
               cl_done_d     = own_oh;
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
         end
         ST_WAIT_DATA: begin
            if (rd_data_valid) begin
               beat_cnt_d = LEN_W'(1);
               state_d    = ST_XFER;
`ifdef DDR2_RD_ARB_TIMEOUT_EN
            end else if (wait_cnt_q == TO_LAST) begin
               cl_done_d     = own_oh;
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
         end
         ST_XFER: begin
            if (rd_data_valid) begin
               if (beat_cnt_q != '1) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end else begin
               // done is registered here so it is high while in ST_DONE
               cl_done_d = own_oh;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (beat_cnt_q != len_q) begin
               len_err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rd_mem_req_q <= 1'b0;
         cl_gnt_q     <= '0;
         cl_done_q    <= '0;
         cl_owner_q   <= 2'd0;
         rr_ptr_q     <= 2'(NUM_REQ - 1);
         addr_q       <= '0;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         len_err_q    <= 1'b0;
`ifdef DDR2_RD_ARB_TIMEOUT_EN
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rd_mem_req_q <= rd_mem_req_d;
         cl_gnt_q     <= cl_gnt_d;
         cl_done_q    <= cl_done_d;
         cl_owner_q   <= cl_owner_d;
         rr_ptr_q     <= rr_ptr_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         len_err_q    <= len_err_d;
`ifdef DDR2_RD_ARB_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign rd_mem_req  = rd_mem_req_q;
   assign cl_gnt      = cl_gnt_q;
   assign cl_done     = cl_done_q;
   assign cl_owner    = cl_owner_q;
   assign rd_mem_addr = addr_q;
   assign rd_xfr_len  = len_q;
   assign len_err     = len_err_q;
   assign busy        = (state_q != ST_IDLE);
`ifdef DDR2_RD_ARB_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`endif

endmodule

// File: doc/ddr2_rd_arbiter.md
Name: ddr2_rd_arbiter

Overview:
- Shares the single ddr2_mgr read port (rd_mem_req / rd_mem_grant / rd_data_valid) between up to 4 read clients, e.g. the display line fetcher and the fractal unit.
- Round-robin arbitration, one outstanding transfer at a time.
- Latches the winner's address and length, forwards the request, and tracks the burst until rd_data_valid drops.
- Returns a grant pulse and a done pulse to the owning client, and checks beat count against the requested length.

Parameters:
- NUM_REQ, 2, number of clients (2..4).
- ADDR_W, 25, read address width ({row, col, bank}).
- LEN_W, 10, transfer length width, in 32-bit beats.
- TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  arbiter clock; same domain as ddr2_mgr rd_* interface.
- rst  in  1  synchronous reset, active-high.
- cl_req  in  NUM_REQ  per-client request, level; held until the matching cl_gnt bit pulses.
- cl_addr  in  NUM_REQ*ADDR_W  per-client start address, flattened, client i at [i*ADDR_W +: ADDR_W].
- cl_len  in  NUM_REQ*LEN_W  per-client beat count, flattened likewise.
- cl_gnt  out  NUM_REQ  1-cycle pulse when ddr2_mgr accepts the client's request.
- cl_done  out  NUM_REQ  1-cycle pulse when the client's data burst ends.
- cl_owner  out  2  index of the current/last owner; qualifies rd_data for clients.
- rd_mem_req  out  1  request to ddr2_mgr.
- rd_mem_addr  out  ADDR_W  latched address of the owner.
- rd_xfr_len  out  LEN_W  latched length of the owner.
- rd_mem_grant  in  1  ddr2_mgr accept.
- rd_data_valid  in  1  ddr2_mgr data qualifier.
- busy  out  1  high in every state except ST_IDLE.
- len_err  out  1  sticky: beat count differed from rd_xfr_len.

Behaviour:
- Reset values:
  - state = ST_IDLE.
  - All outputs 0.
  - rr_ptr = NUM_REQ-1, so client 0 wins first.
- States: ST_IDLE, ST_REQ, ST_WAIT_DATA, ST_XFER, ST_DONE.

ST_IDLE:
- If any cl_req is set, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
- Latch that client's addr/len into rd_mem_addr/rd_xfr_len and set cl_owner.
- Assert rd_mem_req on the next cycle and go to ST_REQ.
- Arbitration is evaluated only in ST_IDLE; requests arriving in other states wait.

ST_REQ:
- Hold rd_mem_req high.
- On rd_mem_grant: drop rd_mem_req, pulse cl_gnt[owner] for exactly 1 cycle, set rr_ptr = owner, go to ST_WAIT_DATA.

ST_WAIT_DATA:
- On rd_data_valid = 1: beat_cnt = 1, go to ST_XFER.

ST_XFER:
- beat_cnt increments each cycle rd_data_valid = 1, saturating at all-ones.
- On rd_data_valid = 0: go to ST_DONE.

ST_DONE:
- Pulse cl_done[owner] for 1 cycle.
- If beat_cnt != rd_xfr_len, set len_err.
- Return to ST_IDLE.
- Earliest next rd_mem_req is 2 cycles after cl_done.

Edge cases:
- Zero-length request (cl_len = 0) is forwarded unchanged. The first beat then sets len_err at ST_DONE.
- A client dropping cl_req before its grant is not an error. The latched request still completes.
- Simultaneous requests from all clients: each is served once before any is served twice.
- rd_mem_addr, rd_xfr_len and cl_owner are stable from ST_REQ entry until the next ST_IDLE arbitration.
- Reset mid-transfer: immediate return to ST_IDLE, outputs cleared, len_err cleared, no cl_done pulse.

Optional Feature:
- Macro: DDR2_RD_ARB_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to ST_REQ and ST_WAIT_DATA.
  - If it reaches TIMEOUT_CYC in either state, the arbiter drops rd_mem_req, pulses cl_done[owner], and returns to ST_IDLE.
  - It also sets sticky output timeout_err (out, 1, reset 0), which exists only when the macro is defined.
- When undefined: no counter, no timeout_err port, and the arbiter waits indefinitely.

Test Plan:
- Single client: client 0 requests addr 0x0001000, len 0x200; grant after 3 cycles; 512 valid beats -> one rd_mem_req, cl_gnt[0] pulses once, cl_done[0] pulses 1 cycle after valid falls, len_err = 0.
- Contention: cl_req = 2'b11 held, 4 transfers of len 4 -> grant order 0, 1, 0, 1; each rd_mem_addr matches its owner.
- Length mismatch: client 1 len 0x010, bench returns 15 beats -> cl_done[1] pulses and len_err = 1, staying set through the next good transfer.
- Reset mid-burst: assert rst during beat 100 of 512 -> next cycle all outputs 0, state ST_IDLE, no cl_done, len_err = 0.
- Late arrival: client 1 raises cl_req while client 0 is in ST_XFER -> client 1 is not granted until client 0's cl_done, then wins arbitration in ST_IDLE.
- Timeout (DDR2_RD_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16): rd_mem_grant never asserted -> rd_mem_req drops after 16 cycles, cl_done[0] pulses, timeout_err = 1.
